// File: rtl/seg_pkg.sv
// Shared constants and state encoding for the serial 7-segment display shifter.
package seg_pkg;

  localparam int SEG_BITS = 64;
  localparam int DIV_W    = 8;
  localparam int BIT_W    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } seg_state_t;

endpackage

// File: rtl/seg_clk_tick.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles while enabled.
module seg_clk_tick
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;

  // The counter restarts from zero whenever enable drops, so every transfer
  // begins with a full-length low phase.
  always_comb begin
    tick     = enable && (div_reg == DIV_W'(CLK_DIV - 1));
    div_next = div_reg;
    if (!enable || tick) begin
      div_next = '0;
    end else begin
      div_next = div_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_next;
    end
  end

endmodule

// File: rtl/seg_serial_shifter.sv
// Shifts a captured 64-bit segment frame LSB-first into a 74HC164-style chain.
// Optional macro SEG_AUTO_REFRESH_EN: also start a transfer whenever SEG_TXT differs from the last frame sent.
module seg_serial_shifter
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SEG_BITS-1:0] SEG_TXT,
  output logic                busy,
  output logic                done,
  output logic                seg_clk,
  output logic                seg_sout,
  output logic                seg_pen,
  output logic                seg_clrn
);

  seg_state_t          state_reg, state_next;
  logic [SEG_BITS-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]    bit_reg, bit_next;
  logic                clk_reg, clk_next;
  logic                sout_reg, sout_next;
  logic                pen_reg, pen_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                clrn_reg;
  logic                tick;
  logic                launch;

`ifdef SEG_AUTO_REFRESH_EN
  logic [SEG_BITS-1:0] last_frame_reg;

  assign launch = start || (SEG_TXT != last_frame_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_frame_reg <= '0;
    end else if (state_reg == IDLE && launch) begin
      last_frame_reg <= SEG_TXT;
    end
  end
`else
  assign launch = start;
`endif

  seg_clk_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (state_reg == SHIFT),
    .tick   (tick)
  );

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
    clk_next   = clk_reg;
    pen_next   = pen_reg;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          state_next = SHIFT;
          shift_next = SEG_TXT;
          bit_next   = '0;
          clk_next   = 1'b0;
          pen_next   = 1'b0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!clk_reg) begin
            clk_next = 1'b1;
          end else begin
            // Falling edge of seg_clk: advance to the next bit or finish.
            clk_next = 1'b0;
            if (bit_reg == BIT_W'(SEG_BITS - 1)) begin
              state_next = LATCH;
              pen_next   = 1'b1;
            end else begin
              bit_next   = bit_reg + 1'b1;
              shift_next = shift_reg >> 1;
            end
          end
        end
      end
      LATCH: begin
        state_next = IDLE;
        bit_next   = '0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next == SHIFT);
    done_next = (state_next == LATCH);
    sout_next = (state_next == SHIFT) ? shift_next[0] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      bit_reg   <= '0;
      clk_reg   <= 1'b0;
      sout_reg  <= 1'b0;
      pen_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      clrn_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      bit_reg   <= bit_next;
      clk_reg   <= clk_next;
      sout_reg  <= sout_next;
      pen_reg   <= pen_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      clrn_reg  <= 1'b1;
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign seg_clk  = clk_reg;
  assign seg_sout = sout_reg;
  assign seg_pen  = pen_reg;
  assign seg_clrn = clrn_reg;

endmodule

// File: tb/tb_seg_serial_shifter.sv
// Directed bench for seg_serial_shifter: scoreboarded serial data, timing and reset checks.
module tb_seg_serial_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [63:0] seg_txt_a = '0;
  logic [63:0] seg_txt_b = '0;
  logic busy_a, done_a, seg_clk_a, seg_sout_a, seg_pen_a, seg_clrn_a;
  logic busy_b, done_b, seg_clk_b, seg_sout_b, seg_pen_b, seg_clrn_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic exp_q[$];
  int rise_a = 0, done_cnt_a = 0, done_cyc_a = -1;
  int done_cnt_b = 0, last_rise_b = -1;
  int done_cyc_b[$];
  logic prev_clk_a = 1'b0, prev_clk_b = 1'b0;

  always #5 clk = ~clk;

  seg_serial_shifter #(.CLK_DIV(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .SEG_TXT(seg_txt_a),
    .busy(busy_a), .done(done_a), .seg_clk(seg_clk_a), .seg_sout(seg_sout_a),
    .seg_pen(seg_pen_a), .seg_clrn(seg_clrn_a)
  );

  seg_serial_shifter #(.CLK_DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .SEG_TXT(seg_txt_b),
    .busy(busy_b), .done(done_b), .seg_clk(seg_clk_b), .seg_sout(seg_sout_b),
    .seg_pen(seg_pen_b), .seg_clrn(seg_clrn_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [63:0] f);
    for (int i = 0; i < 64; i++) exp_q.push_back(f[i]);
  endtask

  // One clock edge, then sample both DUTs 1 time unit later.
  task automatic step();
    logic e;
    @(posedge clk);
    #1;
    cyc++;
    if (seg_clk_a && !prev_clk_a) begin
      rise_a++;
      if (exp_q.size() == 0) begin
        chk("sout_unexpected_edge", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sout_bit", 64'(seg_sout_a), 64'(e));
      end
    end
    prev_clk_a = seg_clk_a;
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
    if (seg_clk_b && !prev_clk_b) begin
      if (last_rise_b >= 0) chk("b_clk_period", 64'(cyc - last_rise_b), 64'd2);
      last_rise_b = cyc;
    end
    prev_clk_b = seg_clk_b;
    if (done_b) begin
      done_cnt_b++;
      done_cyc_b.push_back(cyc);
      last_rise_b = -1;
    end
    $display("cyc=%0d a:busy=%0b done=%0b clk=%0b sout=%0b pen=%0b clrn=%0b b:busy=%0b done=%0b",
             cyc, busy_a, done_a, seg_clk_a, seg_sout_a, seg_pen_a, seg_clrn_a, busy_b, done_b);
  endtask

  initial begin
    int s, sb, rise0, d0, db0;

    // Reset held three cycles.
    rst = 1'b1;
    repeat (3) begin
      step();
      chk("reset_outputs", 64'({busy_a, done_a, seg_clk_a, seg_sout_a, seg_pen_a, seg_clrn_a}), 64'd0);
    end
    rst = 1'b0;
    step();
    chk("clrn_after_reset", 64'(seg_clrn_a), 64'd1);
    chk("idle_busy", 64'(busy_a), 64'd0);
    chk("idle_pen", 64'(seg_pen_a), 64'd0);

    // Frame 0xA5 with stray start pulses mid-transfer.
    seg_txt_a = 64'h0000_0000_0000_00A5;
    push_frame(seg_txt_a);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    s = cyc;
    rise0 = rise_a;
    d0 = done_cnt_a;
    chk("busy_after_start", 64'(busy_a), 64'd1);
    chk("pen_while_shift", 64'(seg_pen_a), 64'd0);
    for (int i = 1; i <= 300 && done_cnt_a == d0; i++) begin
      if (i == 9 || i == 99) start_a = 1'b1;
      step();
      start_a = 1'b0;
    end
    chk("done_cycle", 64'(done_cyc_a), 64'(s + 256));
    chk("done_level", 64'(done_a), 64'd1);
    chk("busy_at_done", 64'(busy_a), 64'd0);
    chk("pen_at_done", 64'(seg_pen_a), 64'd1);
    chk("rise_count", 64'(rise_a - rise0), 64'd64);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    repeat (10) step();
    chk("single_done", 64'(done_cnt_a - d0), 64'd1);
    chk("pen_held_idle", 64'(seg_pen_a), 64'd1);
    chk("sout_idle", 64'(seg_sout_a), 64'd0);
    chk("busy_idle", 64'(busy_a), 64'd0);

    // Reset during bit 30 of an all-ones frame.
    seg_txt_a = '1;
    push_frame(seg_txt_a);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    rise0 = rise_a;
    d0 = done_cnt_a;
    for (int i = 0; i < 400 && (rise_a - rise0) < 30; i++) step();
    chk("rises_before_abort", 64'(rise_a - rise0), 64'd30);
    step();
    step();
    rst = 1'b1;
    step();
    chk("abort_outputs", 64'({busy_a, done_a, seg_clk_a, seg_sout_a, seg_pen_a, seg_clrn_a}), 64'd0);
    seg_txt_a = '0;
    exp_q.delete();
    rst = 1'b0;
    repeat (5) step();
    chk("abort_no_done", 64'(done_cnt_a - d0), 64'd0);
    chk("abort_clrn_back", 64'(seg_clrn_a), 64'd1);
    chk("abort_busy", 64'(busy_a), 64'd0);

    // CLK_DIV=1 with start held: back-to-back frames.
    start_b = 1'b1;
    step();
    sb = cyc;
    db0 = done_cnt_b;
    done_cyc_b.delete();
    repeat (299) step();
    start_b = 1'b0;
    for (int i = 0; i < 300 && busy_b; i++) step();
    chk("b_done_count", 64'(done_cnt_b - db0), 64'd3);
    chk("b_done0_cycle", 64'(done_cyc_b[0]), 64'(sb + 128));
    chk("b_done1_cycle", 64'(done_cyc_b[1]), 64'(sb + 258));
    repeat (3) step();
    chk("b_busy_end", 64'(busy_b), 64'd0);

`ifdef SEG_AUTO_REFRESH_EN
    // Frame change alone launches one transfer.
    d0 = done_cnt_a;
    rise0 = rise_a;
    seg_txt_a = 64'h1234_5678_9ABC_DEF0;
    push_frame(seg_txt_a);
    step();
    chk("auto_busy", 64'(busy_a), 64'd1);
    for (int i = 0; i < 300 && done_cnt_a == d0; i++) step();
    chk("auto_done", 64'(done_cnt_a - d0), 64'd1);
    chk("auto_rises", 64'(rise_a - rise0), 64'd64);
    chk("auto_queue", 64'(exp_q.size()), 64'd0);
    repeat (20) begin
      step();
      chk("auto_no_retrigger", 64'(busy_a), 64'd0);
    end
`else
    // Without auto refresh a frame change needs start.
    rise0 = rise_a;
    seg_txt_a = 64'h1234_5678_9ABC_DEF0;
    repeat (5) begin
      step();
      chk("no_auto_busy", 64'(busy_a), 64'd0);
    end
    chk("no_auto_rises", 64'(rise_a - rise0), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_serial_shifter.md
Name: seg_serial_shifter

Overview:
Consumer end of the 64-bit SEG_TXT bus produced by the hex-to-7-segment encoder. It captures one 8-digit segment frame and shifts it serially to the board's 74HC164-style display shift chain. It drives the outputs seg_clk, seg_sout, seg_pen and seg_clrn. A start/busy/done handshake lets the top level or CPU-side display controller request refreshes.

Parameters:
CLK_DIV, 2, system clk cycles per seg_clk half-period; legal range 1..255
SEG_BITS, 64, frame width in bits; fixed to 8 digits x 8 segments

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a transfer; sampled only in IDLE
SEG_TXT  in  64  frame from the encoder; digit 0 in [7:0], order {a,b,c,d,e,f,g,p} per byte
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when a frame has been latched to the display
seg_clk  out  1  serial shift clock to the display chain
seg_sout  out  1  serial data, valid across each seg_clk rising edge
seg_pen  out  1  display output enable; low while shifting
seg_clrn  out  1  active-low clear of the display chain

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, seg_clk=0, seg_sout=0, seg_pen=0, seg_clrn=0, shift register=0, bit counter=0, divider=0.
- First clk edge with rst=0: seg_clrn=1 and stays 1 until the next reset.
- States: IDLE, SHIFT, LATCH.
- IDLE: if start=1 at edge k, SEG_TXT is captured into a 64-bit shift register and state goes to SHIFT.
  - From cycle k+1: busy=1, seg_pen=0.
  - Any SEG_TXT change after capture is ignored until the next start.
- SHIFT: bit i (i=0..63) is SEG_TXT[i], so the LSB goes first.
  - Each bit lasts 2*CLK_DIV cycles.
  - First CLK_DIV cycles: seg_clk=0 and seg_sout=bit i.
  - Next CLK_DIV cycles: seg_clk=1 with seg_sout held, so data is stable across the rising edge.
  - After the high phase of bit 63, state goes to LATCH and seg_clk returns to 0.
- LATCH: lasts exactly 1 cycle with done=1, busy=0, seg_pen=1; then state goes to IDLE.
  - seg_pen stays 1 in IDLE until the next transfer starts.
- Latency: done is high in cycle k+1+128*CLK_DIV. With CLK_DIV=2 that is k+257.
- start while busy (SHIFT or LATCH): ignored, with no queueing.
- start held high continuously: a new transfer starts in the cycle after LATCH, i.e. back-to-back frames.
- Reset mid-transfer: immediate return to the reset values above. The partial frame is discarded and seg_clrn pulses low for one cycle.
- Counters:
  - The bit counter is 6 bits and terminates at 63 with no wrap-around into a new frame.
  - The divider counter is 8 bits and counts 0..CLK_DIV-1.
- seg_sout=0 whenever state != SHIFT.

Optional Feature:
Macro SEG_AUTO_REFRESH_EN.
- Defined:
  - A 64-bit last_frame register holds the most recently captured frame; it is reset to 0.
  - In IDLE, a transfer also starts, without start, whenever SEG_TXT != last_frame.
  - The capture and timing rules are identical to a start-initiated transfer.
- Not defined: no last_frame register. Transfers start only on start.

Decomposition:
- Shared package seg_pkg holds:
  - the SEG_BITS=64 constant
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, LATCH=2'd2)
  - the divider counter width (8)
- One sub-module is natural: seg_clk_tick, a CLK_DIV half-period tick generator.
  - Inputs: clk, rst, enable.
  - Output: tick, one cycle every CLK_DIV cycles while enabled.
  - The shifter uses tick to toggle seg_clk and advance the bit index.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset; seg_clrn=1 from the first cycle after release; busy=0, seg_pen=0.
- CLK_DIV=2, SEG_TXT=64'h0000_0000_0000_00A5, start pulse at cycle k:
  - busy=1 at k+1.
  - Sampling seg_sout on 64 seg_clk rising edges gives 1,0,1,0,0,1,0,1 then 56 zeros.
  - done=1 exactly at k+257; seg_pen=1 from k+257.
- start pulses at k+10 and k+100 during the above transfer -> ignored; exactly one done pulse and 64 seg_clk rising edges.
- rst asserted at bit 30 of a transfer with SEG_TXT=64'hFFFF_FFFF_FFFF_FFFF -> next cycle state=IDLE, seg_clk=0, seg_sout=0, seg_pen=0, busy=0, no done pulse.
- CLK_DIV=1, start held high for 300 cycles -> done pulses at k+129 and k+259; seg_clk period is 2 cycles.
- SEG_AUTO_REFRESH_EN defined, no start:
  - SEG_TXT changes from 0 to 64'h1234_5678_9ABC_DEF0 -> a transfer starts next cycle.
  - SEG_TXT held constant afterwards -> no second transfer.
